// File: rtl/prbs_checker_if.sv
// Handshake/result bundle between a serial bit source and prbs_checker.
// The master drives the received bit stream; the slave (checker) drives lock/error status.
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             bit_i;
    logic             valid_i;
    logic             clear_i;
    logic             locked_o;
    logic             err_o;
    logic             lock_loss_o;
    logic [CNT_W-1:0] err_count_o;

    modport master (
        output bit_i, valid_i, clear_i,
        input  locked_o, err_o, lock_loss_o, err_count_o
    );

    modport slave (
        input  bit_i, valid_i, clear_i,
        output locked_o, err_o, lock_loss_o, err_count_o
    );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker: seeds from the line, verifies, then free-runs
// its own reference to count bit errors and detect loss of lock over a sliding window.
module prbs_checker #(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] TAPS        = 7'b1100000,
    parameter int               LOCK_BITS   = 16,
    parameter int               WINDOW      = 64,
    parameter int               LOSS_THRESH = 8,
    parameter int               CNT_W       = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    prbs_checker_if.slave bus
);
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_BITS + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {SEEK, VERIFY, LOCKED} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   sr_reg, sr_next;
    logic [FILL_W-1:0]  fill_reg, fill_next;
    logic [MATCH_W-1:0] match_reg, match_next;
    logic [WIN_W-1:0]   win_bits_reg, win_bits_next;
    logic [WIN_W-1:0]   win_err_reg, win_err_next;
    logic [CNT_W-1:0]   err_count_reg, err_count_next;
    logic               err_reg, err_next;
    logic               loss_reg, loss_next;

    logic               pred;
    logic               mismatch;
    logic               match_hit;
    logic               fill_done;
    logic               match_done;
    logic               win_end;
    logic [WIN_W-1:0]   win_err_sum;
    logic               win_lost;

    assign pred        = ^(sr_reg & TAPS);
    assign mismatch    = bus.bit_i != pred;
    // An all-zero register predicts 0 forever, so it must never count toward lock.
    assign match_hit   = !mismatch && (sr_reg != '0);
    assign fill_done   = fill_reg == FILL_W'(WIDTH - 1);
    assign match_done  = match_hit && (match_reg == MATCH_W'(LOCK_BITS - 1));
    assign win_end     = win_bits_reg == WIN_W'(WINDOW - 1);
    assign win_err_sum = win_err_reg + {{(WIN_W-1){1'b0}}, mismatch};
    assign win_lost    = win_end && (win_err_sum >= WIN_W'(LOSS_THRESH));

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= SEEK;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        if (bus.valid_i) begin
            case (state_reg)
                SEEK:    if (fill_done)  state_next = VERIFY;
                VERIFY:  if (match_done) state_next = LOCKED;
                LOCKED:  if (win_lost)   state_next = SEEK;
                default: state_next = SEEK;
            endcase
        end
    end

    // Datapath and registered-output next values
    always_comb begin
        sr_next        = sr_reg;
        fill_next      = fill_reg;
        match_next     = match_reg;
        win_bits_next  = win_bits_reg;
        win_err_next   = win_err_reg;
        err_count_next = err_count_reg;
        err_next       = 1'b0;
        loss_next      = 1'b0;
        if (bus.valid_i) begin
            case (state_reg)
                SEEK: begin
                    sr_next    = {sr_reg[WIDTH-2:0], bus.bit_i};
                    fill_next  = fill_done ? '0 : fill_reg + 1'b1;
                    match_next = '0;
                end
                VERIFY: begin
                    sr_next       = {sr_reg[WIDTH-2:0], bus.bit_i};
                    match_next    = (match_hit && !match_done) ? match_reg + 1'b1 : '0;
                    win_bits_next = '0;
                    win_err_next  = '0;
                end
                LOCKED: begin
                    // Free-run the reference so one line error cannot propagate.
                    sr_next  = {sr_reg[WIDTH-2:0], pred};
                    err_next = mismatch;
                    if (mismatch && (err_count_reg != '1)) begin
                        err_count_next = err_count_reg + 1'b1;
                    end
                    if (win_end) begin
                        win_bits_next = '0;
                        win_err_next  = '0;
                        loss_next     = win_lost;
                        fill_next     = '0;
                    end else begin
                        win_bits_next = win_bits_reg + 1'b1;
                        win_err_next  = win_err_sum;
                    end
                end
                default: ;
            endcase
        end
        if (bus.clear_i) begin
            err_count_next = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sr_reg        <= '0;
            fill_reg      <= '0;
            match_reg     <= '0;
            win_bits_reg  <= '0;
            win_err_reg   <= '0;
            err_count_reg <= '0;
            err_reg       <= 1'b0;
            loss_reg      <= 1'b0;
        end else begin
            sr_reg        <= sr_next;
            fill_reg      <= fill_next;
            match_reg     <= match_next;
            win_bits_reg  <= win_bits_next;
            win_err_reg   <= win_err_next;
            err_count_reg <= err_count_next;
            err_reg       <= err_next;
            loss_reg      <= loss_next;
        end
    end

    assign bus.locked_o    = (state_reg == LOCKED);
    assign bus.err_o       = err_reg;
    assign bus.lock_loss_o = loss_reg;
    assign bus.err_count_o = err_count_reg;
endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: scenario table, hand-written clear/reset sequences and a
// randomised run, all compared every cycle against a list-based reference model.
module tb_prbs_checker;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic bit_d = 1'b0, valid_d = 1'b0, clear_d = 1'b0;

    prbs_checker_if #(.CNT_W(16)) bus ();
    prbs_checker_if #(.CNT_W(4))  bus_s ();

    assign bus.bit_i     = bit_d;
    assign bus.valid_i   = valid_d;
    assign bus.clear_i   = clear_d;
    assign bus_s.bit_i   = bit_d;
    assign bus_s.valid_i = valid_d;
    assign bus_s.clear_i = clear_d;

    prbs_checker #(.CNT_W(16)) dut   (.clk_i(clk_i), .rst_i(rst_i), .bus(bus.slave));
    prbs_checker #(.CNT_W(4))  dut_s (.clk_i(clk_i), .rst_i(rst_i), .bus(bus_s.slave));

    int tests = 0;
    int fails = 0;
    string phase = "init";

    // One period of PRBS7 (x^7+x^6+1) starting from an all-ones seed
    bit prbs [0:126];

    // Reference model: bits received since (re)entering hunt, reference history when locked
    bit m_rx [$];
    bit m_ref [$];
    bit m_locked;
    int m_run, m_wbits, m_werr, m_cnt;
    bit e_err, e_loss;

    // Observed per-run statistics
    int seen_errs, seen_losses, first_lock, last_lock, bit_no;
    bit prev_locked;

    typedef struct {
        int nbits, zeros, gaps;
        int e_first, e_step, e_num, e_gstep, e_groups;
        int exp_first, exp_last, exp_errs, exp_losses, exp_locked, exp_count, exp_sat;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h", name, phase, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rx.delete();
        m_ref.delete();
        m_locked = 0;
        m_run = 0; m_wbits = 0; m_werr = 0; m_cnt = 0;
        e_err = 0; e_loss = 0;
    endtask

    task automatic model_step(input bit b, input bit v, input bit c);
        int n;
        bit p, nz;
        e_err = 0;
        e_loss = 0;
        if (v) begin
            if (!m_locked) begin
                m_rx.push_back(b);
                n = m_rx.size() - 1;
                if (n >= 7) begin
                    nz = 0;
                    for (int k = n - 7; k < n; k++) nz |= m_rx[k];
                    m_run = (nz && (b == (m_rx[n-7] ^ m_rx[n-6]))) ? m_run + 1 : 0;
                    if (m_run == 16) begin
                        m_locked = 1;
                        m_ref = m_rx[n-6:n];
                        m_wbits = 0;
                        m_werr = 0;
                    end
                end
            end else begin
                p = m_ref[0] ^ m_ref[1];
                void'(m_ref.pop_front());
                m_ref.push_back(p);
                if (b != p) begin
                    e_err = 1;
                    m_werr++;
                    if (m_cnt < 65535) m_cnt++;
                end
                m_wbits++;
                if (m_wbits == 64) begin
                    if (m_werr >= 8) begin
                        m_locked = 0;
                        e_loss = 1;
                        m_rx.delete();
                        m_run = 0;
                    end
                    m_wbits = 0;
                    m_werr = 0;
                end
            end
        end
        if (c) m_cnt = 0;
    endtask

    // Drive one cycle at the falling edge, then compare at the next falling edge.
    task automatic cycle(input bit b, input bit v, input bit c);
        int sat;
        bit_d = b; valid_d = v; clear_d = c;
        model_step(b, v, c);
        if (v) bit_no++;
        @(negedge clk_i);
        sat = (m_cnt > 15) ? 15 : m_cnt;
        check("outputs", int'({bus.locked_o, bus.err_o, bus.lock_loss_o, bus.err_count_o}),
              int'({m_locked, e_err, e_loss, 16'(m_cnt)}));
        check("sat_outputs", int'({bus_s.locked_o, bus_s.err_count_o}), int'({m_locked, 4'(sat)}));
        seen_errs   += int'(bus.err_o);
        seen_losses += int'(bus.lock_loss_o);
        if (bus.locked_o && !prev_locked) begin
            if (first_lock == 0) first_lock = bit_no;
            last_lock = bit_no;
        end
        prev_locked = bus.locked_o;
        valid_d = 0; clear_d = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1;
        valid_d = 0; clear_d = 0; bit_d = 0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        check("reset_state", int'({bus.locked_o, bus.err_o, bus.lock_loss_o, bus.err_count_o}), 0);
        seen_errs = 0; seen_losses = 0; first_lock = 0; last_lock = 0; bit_no = 0;
        prev_locked = 0;
    endtask

    function automatic bit is_err(input vec_t v, input int n);
        for (int g = 0; g < v.e_groups; g++)
            for (int k = 0; k < v.e_num; k++)
                if (n == v.e_first + g * v.e_gstep + k * v.e_step) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        bit b;
        phase = $sformatf("vec%0d", idx);
        do_reset();
        for (int n = 1; n <= v.nbits; n++) begin
            if (v.gaps != 0) begin
                while ($urandom_range(0, 1) == 0) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            end
            b = (v.zeros != 0) ? 1'b0 : (prbs[(n-1) % 127] ^ is_err(v, n));
            cycle(b, 1'b1, 1'b0);
        end
        check("first_lock_bit", first_lock, v.exp_first);
        check("last_lock_bit", last_lock, v.exp_last);
        check("err_pulses", seen_errs, v.exp_errs);
        check("loss_pulses", seen_losses, v.exp_losses);
        check("locked_end", int'(bus.locked_o), v.exp_locked);
        check("count_end", int'(bus.err_count_o), v.exp_count);
        check("sat_count_end", int'(bus_s.err_count_o), v.exp_sat);
        $display("[TB] vec%0d: %0d bits, lock@%0d relock@%0d errs=%0d losses=%0d count=%0d sat=%0d",
                 idx, v.nbits, first_lock, last_lock, seen_errs, seen_losses,
                 bus.err_count_o, bus_s.err_count_o);
    endtask

    initial begin
        int rate, ridx;
        bit rv, rb;

        for (int n = 0; n < 7; n++) prbs[n] = 1'b1;
        for (int n = 7; n < 127; n++) prbs[n] = prbs[n-7] ^ prbs[n-6];

        //          nbits zero gap first step num gstep grp  first last errs loss lck cnt sat
        vecs[0] = '{500, 0, 0,   0,  0, 0,  0, 0,  23,  23,  0, 0, 1,  0,  0};
        vecs[1] = '{300, 0, 0, 100,  1, 1,  0, 1,  23,  23,  1, 0, 1,  1,  1};
        vecs[2] = '{300, 0, 0, 100,  1, 8,  0, 1,  23, 174,  8, 1, 1,  8,  8};
        vecs[3] = '{300, 0, 0,  30,  5, 7, 64, 4,  23,  23, 28, 0, 1, 28, 15};
        vecs[4] = '{300, 1, 0,   0,  0, 0,  0, 0,   0,   0,  0, 0, 0,  0,  0};
        vecs[5] = '{300, 0, 0,  30,  5, 5, 64, 4,  23,  23, 20, 0, 1, 20, 15};
        vecs[6] = '{200, 0, 1,   0,  0, 0,  0, 0,  23,  23,  0, 0, 1,  0,  0};

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Clear coinciding with a counted error: clear wins, err_o still pulses.
        phase = "clear";
        do_reset();
        for (int n = 1; n <= 40; n++) cycle(prbs[n-1] ^ (n == 30), 1'b1, 1'b0);
        check("clear_pre_count", int'(bus.err_count_o), 1);
        cycle(prbs[40] ^ 1'b1, 1'b1, 1'b1);
        check("clear_hit_count", int'(bus.err_count_o), 0);
        check("clear_hit_err", int'(bus.err_o), 1);
        $display("[TB] clear: count=%0d err=%0d after coincident clear", bus.err_count_o, bus.err_o);

        // Asynchronous reset between edges while locked.
        phase = "async_rst";
        for (int n = 42; n <= 60; n++) cycle(prbs[n-1] ^ (n == 50), 1'b1, 1'b0);
        check("pre_rst_state", int'({bus.locked_o, bus.err_count_o}), int'({1'b1, 16'd1}));
        #2 rst_i = 1;
        #1;
        check("async_rst_state", int'({bus.locked_o, bus.err_count_o}), 0);
        check("async_rst_sat", int'({bus_s.locked_o, bus_s.err_count_o}), 0);
        $display("[TB] async reset: locked=%0d count=%0d", bus.locked_o, bus.err_count_o);
        model_reset();
        @(negedge clk_i);
        rst_i = 0;

        // Randomised gaps, error rates and clears against the model.
        phase = "random";
        do_reset();
        rate = 0;
        ridx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 300 == 0) begin
                case ($urandom_range(0, 2))
                    0:       rate = 0;
                    1:       rate = 2;
                    default: rate = 20;
                endcase
            end
            rv = ($urandom_range(0, 3) != 0);
            if (rv) begin
                rb = prbs[ridx % 127] ^ ($urandom_range(0, 99) < rate);
                ridx++;
            end else begin
                rb = 1'($urandom_range(0, 1));
            end
            cycle(rb, rv, $urandom_range(0, 255) == 0);
        end
        $display("[TB] random: %0d valid bits, errs=%0d losses=%0d count=%0d",
                 ridx, seen_errs, seen_losses, bus.err_count_o);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Serial PRBS/LFSR sequence checker. It is the receive-side counterpart of the team's Fibonacci LFSR generator.
- It accepts one bit per valid_i strobe and self-synchronises to the incoming stream.
- Once locked, it counts bit errors and detects loss of lock.
- Used on board bring-up to check a looped-back or externally generated LFSR stream; results are shown on LEDs/counters.

Parameters:
- WIDTH, 7: LFSR length in bits.
- TAPS, 7'b1100000: tap mask. Predicted bit = XOR-reduce(state & TAPS). Default is PRBS7, x^7+x^6+1.
- LOCK_BITS, 16: consecutive correct predictions required to declare lock.
- WINDOW, 64: length of the loss-of-lock observation window, in valid bits.
- LOSS_THRESH, 8: errors within one window that cause loss of lock.
- CNT_W, 16: width of the error counter.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- bit_i  input  1  received serial bit, sampled only when valid_i=1
- valid_i  input  1  bit strobe; one bit per high cycle, gaps allowed
- clear_i  input  1  synchronous clear of err_count_o
- locked_o  output  1  high while in LOCKED
- err_o  output  1  one-cycle pulse per mismatched bit while LOCKED
- lock_loss_o  output  1  one-cycle pulse on the LOCKED->SEEK transition
- err_count_o  output  CNT_W  saturating count of errors seen while LOCKED

Behaviour:
- Registers:
  - state register sr[WIDTH-1:0]
  - FSM {SEEK, VERIFY, LOCKED}
  - fill counter, match counter, window-bit counter, window-error counter
  - err_count
- Reset (rst_i asynchronous): FSM=SEEK, sr=0, all counters 0, all outputs 0. Reset mid-operation discards lock immediately.
- Outputs are registered. Each output reflects the valid bit sampled on the previous clock edge, i.e. 1-cycle latency from the valid_i cycle.
- valid_i=0: no state, counter or FSM change; pulses deassert.
- pred = ^(sr & TAPS). Shifting means sr <= {sr[WIDTH-2:0], x}, where x is the incoming bit or pred as stated per state.
- SEEK:
  - Shift in bit_i on each valid bit; fill++.
  - After the WIDTH-th bit, go to VERIFY; fill=0, match=0.
- VERIFY:
  - Shift in bit_i (receiver reseeds from the line).
  - If bit_i==pred and sr!=0: match++. Otherwise match=0.
  - When match reaches LOCK_BITS: go to LOCKED; window counters cleared.
  - An all-zero sr never counts as a match, so an all-zero stream never locks.
- LOCKED:
  - Shift in pred, not bit_i. The reference free-runs, so a single line error is counted once, with no error multiplication.
  - On bit_i!=pred: err_o pulses; err_count increments, saturating at 2^CNT_W-1; window-error count increments.
  - Window-bit counter increments per valid bit. On the WINDOW-th bit (this bit's error included), the window is evaluated:
    - window errors >= LOSS_THRESH: go to SEEK (fill=0), pulse lock_loss_o, locked_o falls.
    - otherwise: both window counters reset to 0.
- Lock acquisition from a clean stream takes exactly WIDTH+LOCK_BITS valid bits. locked_o rises the cycle after the last of them.
- clear_i:
  - Sets err_count to 0 on the next edge.
  - If clear_i and a counted error coincide, clear wins and the result is 0.
  - Does not affect FSM, window counters or err_o.
- err_count is retained across loss/reacquisition of lock; only rst_i or clear_i zero it.
- err_o and lock_loss_o may pulse in the same cycle when the window's final bit is an error.

Test Plan:
- Clean lock: PRBS7 from seed 7'h7F, valid_i every cycle, 500 bits. locked_o rises after valid bit 23 (7+16) and stays high; err_o never pulses; err_count_o=0; lock_loss_o never pulses.
- Single error: after lock, invert bit 100. Exactly one err_o pulse, err_count_o=1, locked_o stays 1. The following bits produce no further errors.
- Burst and relock: after lock, invert 8 bits inside one 64-bit window. lock_loss_o pulses once at the window's 64th bit and locked_o=0. After 23 further clean bits locked_o=1 again; err_count_o=8 is retained.
- Sub-threshold: 7 errors per window over 4 windows. No lock loss; err_count_o=28.
- Gaps, all-zero input, saturation:
  - Randomised valid_i gaps (~50% duty): same lock point in valid-bit terms.
  - All-zero stream for 300 bits: locked_o never rises.
  - CNT_W=4 with 20 errors spaced under threshold: err_count_o holds 15.
- Clear and reset:
  - clear_i in the same cycle as an error: err_count_o=0 next cycle.
  - rst_i asserted mid-LOCKED, asynchronous between edges: locked_o and err_count_o drop to 0 immediately.
